// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: opcodes, instruction
// field positions and the access FSM encoding.
package mem_stage_ctrl_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int F3_LSB     = 12;
    localparam int F3_MSB     = 14;
    localparam int DECODE_W   = F3_MSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request port of the memory stage: access request, qualifiers
// describing the access and the completion strobe from the memory.
interface mem_stage_ctrl_if;

    logic       mem_req;
    logic       mem_ready;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] mem_size;
    logic       mem_unsigned;

    modport master (
        output mem_req,
        output MemRead,
        output MemWrite,
        output mem_size,
        output mem_unsigned,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemRead,
        input  MemWrite,
        input  mem_size,
        input  mem_unsigned,
        output mem_ready
    );

endinterface

// File: rtl/mem_stage_ctrl_decode.sv
// Purely combinational decode of the memory-stage instruction into the
// memory-access qualifiers and the writeback/forwarding controls.
module mem_ctrl_decode
    import mem_stage_ctrl_pkg::*;
#(
    parameter logic [6:0] OP_LOAD   = OPCODE_LOAD,
    parameter logic [6:0] OP_STORE  = OPCODE_STORE,
    parameter logic [6:0] OP_BRANCH = OPCODE_BRANCH
) (
    input  logic [DECODE_W-1:0] inst,
    output logic [4:0]          rd,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic [1:0]          mem_size,
    output logic                mem_unsigned
);

    logic [6:0] op;
    logic [2:0] funct3;
    logic       is_load;
    logic       is_store;

    assign op       = inst[OP_MSB:OP_LSB];
    assign funct3   = inst[F3_MSB:F3_LSB];
    assign rd       = inst[RD_MSB:RD_LSB];

    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);

    assign mem_read     = is_load;
    assign mem_write    = is_store;
    assign mem_to_reg   = is_load;
    // Size and sign qualifiers are forced quiet for anything that is not an access.
    assign mem_size     = (is_load || is_store) ? funct3[1:0] : 2'b00;
    assign mem_unsigned = is_load & funct3[2];

    assign reg_write = (op != OP_BRANCH) && (op != OP_STORE) && (rd != 5'd0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage: holds the instruction register, issues one data
// memory access per memory instruction and freezes upstream while waiting.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter logic [6:0] OP_LOAD   = OPCODE_LOAD,
    parameter logic [6:0] OP_STORE  = OPCODE_STORE,
    parameter logic [6:0] OP_BRANCH = OPCODE_BRANCH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst_in,
    input  logic                  stall_in,
    input  logic                  flush_in,
    output logic [31:0]           inst_out,
    output logic [4:0]            rd,
    output logic                  RegWrite,
    output logic                  MemtoReg,
    output logic                  stall_out,
    mem_stage_ctrl_if.master      bus
);

    mem_state_t state;
    mem_state_t state_next;

    logic       dec_mem_read;
    logic       dec_mem_write;
    logic [1:0] dec_mem_size;
    logic       dec_mem_unsigned;
    logic       mem_op;
    logic       mem_req_c;
    logic       stall_c;
    logic       advance;

    mem_ctrl_decode #(
        .OP_LOAD   (OP_LOAD),
        .OP_STORE  (OP_STORE),
        .OP_BRANCH (OP_BRANCH)
    ) u_decode (
        .inst         (inst_out[DECODE_W-1:0]),
        .rd           (rd),
        .reg_write    (RegWrite),
        .mem_read     (dec_mem_read),
        .mem_write    (dec_mem_write),
        .mem_to_reg   (MemtoReg),
        .mem_size     (dec_mem_size),
        .mem_unsigned (dec_mem_unsigned)
    );

    assign mem_op           = dec_mem_read | dec_mem_write;
    assign bus.MemRead      = dec_mem_read;
    assign bus.MemWrite     = dec_mem_write;
    assign bus.mem_size     = dec_mem_size;
    assign bus.mem_unsigned = dec_mem_unsigned;
    assign bus.mem_req      = mem_req_c;
    assign stall_out        = stall_c;

    // DONE remembers that the held instruction already completed its access,
    // so a long downstream hold never turns into a second request.
    always_comb begin
        state_next = state;
        mem_req_c  = 1'b0;
        stall_c    = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    mem_req_c = 1'b1;
                    if (bus.mem_ready) begin
                        if (stall_in) state_next = DONE;
                        else          advance    = 1'b1;
                    end else begin
                        state_next = BUSY;
                        stall_c    = 1'b1;
                    end
                end else begin
                    advance = ~stall_in;
                end
            end
            BUSY: begin
                mem_req_c = 1'b1;
                stall_c   = 1'b1;
                // Completion edge retires the instruction even though upstream is frozen.
                if (bus.mem_ready) begin
                    if (stall_in) begin
                        state_next = DONE;
                    end else begin
                        state_next = IDLE;
                        advance    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!stall_in) begin
                    state_next = IDLE;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset drops any in-flight access; flush only picks the value loaded on an advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            inst_out <= 32'd0;
        end else begin
            state <= state_next;
            if (advance) begin
                inst_out <= flush_in ? 32'd0 : inst_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a transaction-level model checked
// every cycle plus directed scenarios with hand-computed expectations.
module tb_mem_stage_ctrl;

    localparam logic [31:0] LW    = 32'h0000A283;
    localparam logic [31:0] SB    = 32'h00B50023;
    localparam logic [31:0] LBU   = 32'h00054303;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] ADDI1 = 32'h00100093;
    localparam logic [31:0] ADDI0 = 32'h00000013;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] inst_in;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] inst_out;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemtoReg;
    logic        stall_out;

    mem_stage_ctrl_if bus();

    mem_stage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .inst_in   (inst_in),
        .stall_in  (stall_in),
        .flush_in  (flush_in),
        .inst_out  (inst_out),
        .rd        (rd),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .stall_out (stall_out),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: the held instruction, whether its access already
    // completed, and whether it has already waited at least one cycle.
    logic [31:0] m_inst;
    bit          m_done;
    bit          m_waited;
    int          m_completions;
    int          dut_completions;

    function automatic logic [6:0] op_of(input logic [31:0] i);
        return 7'(i & 32'h7F);
    endfunction
    function automatic logic [2:0] f3_of(input logic [31:0] i);
        return 3'((i >> 12) & 32'h7);
    endfunction
    function automatic logic [4:0] rd_of(input logic [31:0] i);
        return 5'((i >> 7) & 32'h1F);
    endfunction
    function automatic bit is_ld(input logic [31:0] i);
        return op_of(i) == 7'h03;
    endfunction
    function automatic bit is_st(input logic [31:0] i);
        return op_of(i) == 7'h23;
    endfunction
    function automatic bit m_req();
        return (is_ld(m_inst) || is_st(m_inst)) && !m_done;
    endfunction
    function automatic bit m_stall();
        return m_req() && (m_waited || !bus.mem_ready);
    endfunction
    function automatic bit m_adv();
        return !stall_in && (!m_req() || bus.mem_ready);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inst   <= 32'd0;
            m_done   <= 1'b0;
            m_waited <= 1'b0;
        end else begin
            if (m_req() && bus.mem_ready) m_completions <= m_completions + 1;
            if (m_adv()) begin
                m_inst   <= flush_in ? 32'd0 : inst_in;
                m_done   <= 1'b0;
                m_waited <= 1'b0;
            end else if (m_req() && bus.mem_ready) begin
                m_done <= 1'b1;
            end else if (m_req()) begin
                m_waited <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && bus.mem_req && bus.mem_ready) dut_completions <= dut_completions + 1;
    end

    always @(negedge clk) begin
        checkOutput("model inst_out", inst_out, m_inst);
        checkOutput("model rd", {27'd0, rd}, {27'd0, rd_of(m_inst)});
        checkOutput("model RegWrite", {31'd0, RegWrite},
                    {31'd0, (op_of(m_inst) != 7'h63) && !is_st(m_inst) && (rd_of(m_inst) != 5'd0)});
        checkOutput("model MemRead", {31'd0, bus.MemRead}, {31'd0, is_ld(m_inst)});
        checkOutput("model MemWrite", {31'd0, bus.MemWrite}, {31'd0, is_st(m_inst)});
        checkOutput("model MemtoReg", {31'd0, MemtoReg}, {31'd0, is_ld(m_inst)});
        checkOutput("model mem_size", {30'd0, bus.mem_size},
                    {30'd0, (is_ld(m_inst) || is_st(m_inst)) ? f3_of(m_inst) % 4 : 3'd0});
        checkOutput("model mem_unsigned", {31'd0, bus.mem_unsigned},
                    {31'd0, is_ld(m_inst) && (f3_of(m_inst) >= 3'd4)});
        checkOutput("model mem_req", {31'd0, bus.mem_req}, {31'd0, m_req()});
        checkOutput("model stall_out", {31'd0, stall_out}, {31'd0, m_stall()});
    end

    task automatic applyStimulus(input logic [31:0] inst, input logic stall,
                                 input logic flush, input logic ready);
        @(posedge clk);
        #1;
        inst_in       = inst;
        stall_in      = stall;
        flush_in      = flush;
        bus.mem_ready = ready;
        @(negedge clk);
    endtask

    initial begin
        m_completions   = 0;
        dut_completions = 0;
        rst             = 1'b0;
        inst_in         = 32'd0;
        stall_in        = 1'b0;
        flush_in        = 1'b0;
        bus.mem_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset inst_out", inst_out, 32'd0);
        checkOutput("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("reset stall_out", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // lw completing in its first cycle
        applyStimulus(LW, 0, 0, 0);
        applyStimulus(ADDI1, 0, 0, 1);
        checkOutput("lw MemRead", {31'd0, bus.MemRead}, 32'd1);
        checkOutput("lw mem_size", {30'd0, bus.mem_size}, 32'd2);
        checkOutput("lw RegWrite", {31'd0, RegWrite}, 32'd1);
        checkOutput("lw rd", {27'd0, rd}, 32'd5);
        checkOutput("lw stall_out", {31'd0, stall_out}, 32'd0);
        checkOutput("lw mem_req", {31'd0, bus.mem_req}, 32'd1);
        applyStimulus(SB, 0, 0, 0);
        checkOutput("lw next loaded", inst_out, ADDI1);

        // sb waiting three cycles for memory
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NOP, 0, 0, 0);
            checkOutput("sb wait mem_req", {31'd0, bus.mem_req}, 32'd1);
            checkOutput("sb wait stall_out", {31'd0, stall_out}, 32'd1);
            checkOutput("sb wait inst_out", inst_out, SB);
            checkOutput("sb wait RegWrite", {31'd0, RegWrite}, 32'd0);
        end
        applyStimulus(LBU, 0, 0, 1);
        checkOutput("sb done mem_req", {31'd0, bus.mem_req}, 32'd1);

        // lbu held downstream for four cycles, memory ready in the first
        applyStimulus(NOP, 1, 0, 1);
        checkOutput("lbu inst_out", inst_out, LBU);
        checkOutput("lbu mem_req first", {31'd0, bus.mem_req}, 32'd1);
        checkOutput("lbu mem_unsigned", {31'd0, bus.mem_unsigned}, 32'd1);
        checkOutput("lbu mem_size", {30'd0, bus.mem_size}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NOP, 1, 0, 1);
            checkOutput("lbu held mem_req", {31'd0, bus.mem_req}, 32'd0);
            checkOutput("lbu held inst_out", inst_out, LBU);
        end

        // flush on an advance loads a bubble
        applyStimulus(LW, 0, 1, 0);
        applyStimulus(LW, 0, 0, 0);
        checkOutput("flush inst_out", inst_out, 32'd0);
        checkOutput("flush RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("flush MemRead", {31'd0, bus.MemRead}, 32'd0);

        // flush while waiting on memory has no effect
        applyStimulus(NOP, 0, 1, 0);
        applyStimulus(NOP, 0, 1, 0);
        checkOutput("busy flush inst_out", inst_out, LW);
        applyStimulus(ADDI0, 0, 0, 1);
        applyStimulus(BEQ, 0, 0, 0);
        checkOutput("addi x0 inst_out", inst_out, ADDI0);
        checkOutput("addi x0 RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("addi x0 mem_req", {31'd0, bus.mem_req}, 32'd0);
        applyStimulus(SW, 0, 0, 0);
        checkOutput("beq RegWrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("beq rd", {27'd0, rd}, 32'd8);

        // completion while held downstream must not be reissued
        applyStimulus(NOP, 0, 0, 0);
        applyStimulus(NOP, 1, 0, 1);
        checkOutput("sw busy stall mem_req", {31'd0, bus.mem_req}, 32'd1);
        applyStimulus(NOP, 1, 0, 1);
        checkOutput("sw no reissue mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("sw no reissue inst_out", inst_out, SW);
        checkOutput("sw no reissue stall_out", {31'd0, stall_out}, 32'd0);

        // reset in the middle of an outstanding access
        applyStimulus(LW, 0, 0, 0);
        applyStimulus(NOP, 0, 0, 0);
        applyStimulus(NOP, 0, 0, 0);
        checkOutput("pre-reset stall_out", {31'd0, stall_out}, 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async reset inst_out", inst_out, 32'd0);
        checkOutput("async reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("async reset stall_out", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(SW, 0, 0, 0);
        checkOutput("post-reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("post-reset stall_out", {31'd0, stall_out}, 32'd0);
        applyStimulus(NOP, 0, 0, 1);
        checkOutput("post-reset sw stall_out", {31'd0, stall_out}, 32'd0);
        applyStimulus(NOP, 0, 0, 0);
        checkOutput("post-reset advance", inst_out, NOP);
        applyStimulus(NOP, 0, 0, 0);

        checkOutput("completions literal", 32'(dut_completions), 32'd6);
        checkOutput("completions model", 32'(dut_completions), 32'(m_completions));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- OP_LOAD, 7'b0000011, load opcode.
- OP_STORE, 7'b0100011, store opcode.
- OP_BRANCH, 7'b1100011, branch opcode.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous, active-low.
- inst_in, in, 32, instruction from the execute stage.
- stall_in, in, 1, downstream hold request; inst_out must not advance.
- flush_in, in, 1, load a bubble (32'd0) instead of inst_in when advancing.
- mem_ready, in, 1, data memory has completed the current access this cycle.
- inst_out, out, 32, registered memory-stage instruction, passed to the writeback stage.
- rd, out, 5, inst_out[11:7].
- RegWrite, out, 1, memory-stage result writes rd (forwarding qualifier).
- MemRead, out, 1, inst_out is a load.
- MemWrite, out, 1, inst_out is a store.
- MemtoReg, out, 1, the writeback value comes from memory.
- mem_size, out, 2, access size: 00 byte, 01 half, 10 word.
- mem_unsigned, out, 1, zero-extend load data.
- mem_req, out, 1, access request to data memory.
- stall_out, out, 1, freeze request to all upstream stages.

Function
REQ-003 Decode SHALL be combinational from inst_out only:
- MemRead = (op==OP_LOAD).
- MemWrite = (op==OP_STORE).
- MemtoReg = MemRead.
- mem_size = funct3[1:0].
- mem_unsigned = MemRead & funct3[2].
- MemRead, MemWrite, mem_size and mem_unsigned are 0 for non-memory ops.

REQ-004 RegWrite SHALL be 1 iff op is not OP_BRANCH, op is not OP_STORE, and rd is not 0.

REQ-005 The register SHALL advance, unless held per REQ-006, as follows:
- flush_in=1: inst_out <= 32'd0.
- flush_in=0: inst_out <= inst_in.

REQ-006 The register SHALL hold inst_out whenever either of these is true:
- stall_out=1.
- stall_in=1.

REQ-007 An FSM SHALL have the states IDLE, BUSY and DONE.

REQ-008 In IDLE with a memory op (MemRead|MemWrite):
- mem_req=1.
- mem_ready=1 and stall_in=1: next state is DONE.
- mem_ready=1 and stall_in=0: stay in IDLE; the register advances.
- mem_ready=0: next state is BUSY; stall_out=1 this cycle.

REQ-009 In IDLE with a non-memory op:
- mem_req=0.
- stall_out=0.
- The state stays IDLE.

REQ-010 In BUSY:
- mem_req=1.
- stall_out=1.
- On mem_ready: the next state is DONE if stall_in=1, else IDLE.
- On the transition to IDLE, the register advances at that same edge.

REQ-011 In DONE:
- mem_req=0.
- stall_out=0.
- The state stays DONE while stall_in=1.
- When stall_in=0, the register advances and the next state is IDLE.

REQ-012 stall_out SHALL be combinational, equal to BUSY | (IDLE & memop & ~mem_ready).

REQ-013 Each instruction SHALL cause exactly one completed access, whatever the stall or hold duration.

REQ-014 flush_in SHALL never cancel the instruction in inst_out.
- flush_in only selects the value loaded at an advance.
- flush_in while held has no effect.

REQ-015 When stall_in and mem_ready are both 1 in the same cycle in BUSY, the FSM SHALL go to DONE and SHALL NOT reissue the access.

REQ-016 mem_ready outside a request (mem_req=0) SHALL be ignored.

Reset
REQ-017 When rst=0, asynchronously:
- inst_out SHALL be 32'd0.
- The state SHALL be IDLE.

REQ-018 Resulting output values under reset SHALL be:
- rd=0, RegWrite=0.
- MemRead=0, MemWrite=0, MemtoReg=0.
- mem_size=0, mem_unsigned=0.
- mem_req=0, stall_out=0.

REQ-019 Reset asserted mid-access (BUSY) SHALL abandon the access with no completion recorded.

Structure
REQ-020 The shared package SHALL hold:
- the opcode constants;
- the instruction field ranges (rd 11:7, funct3 14:12, op 6:0);
- the FSM state encoding.

REQ-021 One combinational sub-module, mem_ctrl_decode (inst_out to decode outputs), is natural; the FSM and the register SHALL remain in mem_stage_ctrl.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset: rst=0 mid-BUSY -> inst_out=0, mem_req=0, stall_out=0 immediately. After release, state is IDLE.
- lw x5 (32'h0000A283), mem_ready=1 same cycle -> MemRead=1, mem_size=10, RegWrite=1, rd=5, stall_out=0; next instruction loads at the next edge.
- sb (32'h00B50023), mem_ready low 3 cycles -> mem_req=1 and stall_out=1 for 3 cycles, inst_out held, RegWrite=0. Advances on the 4th cycle.
- lbu x6 (32'h00054303) with stall_in=1 for 4 cycles, mem_ready=1 in cycle 1 -> mem_req only in cycle 1 (DONE afterwards); inst_out held 4 cycles; mem_unsigned=1, mem_size=00.
- flush_in=1 while advancing -> inst_out=0, RegWrite=0, MemRead=0. flush_in=1 during BUSY -> no effect.
- addi x0 (32'h00000013) -> RegWrite=0, mem_req=0. Any beq -> RegWrite=0.
